// File: rtl/line_pingpong_reader.sv
// Two-bank line store: the depacketizer fills one bank while the other is replayed
// as a valid/ready pixel stream; a line is only read once it has been completely written.
module line_pingpong_reader #(
  parameter int DATA_W    = 24,
  parameter int MAX_WIDTH = 1920,
  parameter int CNT_W     = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  img_width,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic [1:0]        bank_full,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2
  } rd_state_t;

  logic [DATA_W-1:0] mem [2][MAX_WIDTH];

  rd_state_t         state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              overflow_q, overflow_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              width_ok, wr_fire, wr_line_end;
  logic              rd_fire, rd_line_end, rd_load, rd_sel_bank;
  logic [CNT_W-1:0]  last_idx, rd_sel_addr, rd_next_cnt;
  logic [1:0]        set_mask, clr_mask;

  // Write side: accept pixels into the current bank and flip banks at end of line.
  always_comb begin
    width_ok    = (img_width != {CNT_W{1'b0}});
    last_idx    = img_width - CNT_W'(1);
    wr_ready    = !reset && !bank_full_q[wr_bank_q] && width_ok;
    wr_fire     = wr_valid && wr_ready;
    wr_line_end = wr_fire && (wr_cnt_q == last_idx);
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    if (wr_line_end) begin
      wr_cnt_d  = {CNT_W{1'b0}};
      wr_bank_d = ~wr_bank_q;
    end else if (wr_fire) begin
      wr_cnt_d  = wr_cnt_q + CNT_W'(1);
    end else begin
      wr_cnt_d  = wr_cnt_q;
    end
    overflow_d = overflow_q || (wr_valid && !wr_ready && width_ok);
  end

  // Read side: the output register doubles as the RAM read register, so a
  // transfer reloads it with the next pixel (or the next line's first pixel).
  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_load     = 1'b0;
    rd_sel_bank = rd_bank_q;
    rd_sel_addr = rd_cnt_q;
    rd_line_end = 1'b0;
    rd_fire     = rd_valid_q && rd_ready;
    rd_next_cnt = rd_cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        rd_load    = 1'b1;
        rd_valid_d = 1'b1;
        rd_last_d  = (rd_cnt_q == last_idx);
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        if (rd_fire && rd_last_q) begin
          rd_line_end = 1'b1;
          rd_bank_d   = ~rd_bank_q;
          rd_cnt_d    = {CNT_W{1'b0}};
          if (bank_full_q[~rd_bank_q]) begin
            rd_load     = 1'b1;
            rd_sel_bank = ~rd_bank_q;
            rd_sel_addr = {CNT_W{1'b0}};
            rd_last_d   = (last_idx == {CNT_W{1'b0}});
          end else begin
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
            state_d     = S_IDLE;
          end
        end else if (rd_fire) begin
          rd_load     = 1'b1;
          rd_sel_addr = rd_next_cnt;
          rd_cnt_d    = rd_next_cnt;
          rd_last_d   = (rd_next_cnt == last_idx);
        end else begin
          state_d     = S_STREAM;
        end
      end
      default: begin
        state_d    = S_IDLE;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
      end
    endcase
    rd_data_d   = rd_load ? mem[rd_sel_bank][rd_sel_addr] : rd_data_q;
    // Set and clear always hit different banks, so both can apply on one edge.
    set_mask    = wr_line_end ? (2'b01 << wr_bank_q) : 2'b00;
    clr_mask    = rd_line_end ? (2'b01 << rd_bank_q) : 2'b00;
    bank_full_d = (bank_full_q | set_mask) & ~clr_mask;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= {CNT_W{1'b0}};
      rd_cnt_q    <= {CNT_W{1'b0}};
      bank_full_q <= 2'b00;
      overflow_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      bank_full_q <= bank_full_d;
      overflow_q  <= overflow_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Pixel RAM write port.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank_q][wr_cnt_q] <= wr_data;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign bank_full = bank_full_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_line_pingpong_reader.sv
// Bench for line_pingpong_reader: directed scenarios plus randomized traffic checked
// against a line-queue model (lines land whole, leave whole, at most two held).
module tb_line_pingpong_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] img_width = 11'd4;
  logic        wr_valid = 1'b0;
  logic [23:0] wr_data = 24'd0;
  logic        wr_ready;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic        rd_last;
  logic        rd_ready = 1'b0;
  logic [1:0]  bank_full;
  logic        overflow;

  line_pingpong_reader dut (
    .clk(clk), .reset(reset), .img_width(img_width),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .bank_full(bank_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int written = 0, released = 0, done_edge = -1, rise_edge = -1;
  int wr_ready_err = 0, bank_err = 0, ovf_err = 0, hold_err = 0;
  bit ovf_exp = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
  logic [23:0] prev_data = 24'd0;
  logic [23:0] partial[$], exp_data[$], got_data[$];
  bit          exp_last[$], got_last[$];
  int          got_edge[$];

  // Model: bank k%2 holds line k; lines leave in order, so stored count gives the flags.
  function automatic logic [1:0] exp_bank_full();
    int s;
    s = written - released;
    if (s <= 0) return 2'b00;
    else if (s == 1) return ((released % 2) == 0) ? 2'b01 : 2'b10;
    else return 2'b11;
  endfunction

  task automatic clear_capture();
    partial.delete(); exp_data.delete(); exp_last.delete();
    got_data.delete(); got_last.delete(); got_edge.delete();
    wr_ready_err = 0; bank_err = 0; ovf_err = 0; hold_err = 0;
    done_edge = -1; rise_edge = -1;
  endtask

  task automatic model_reset();
    written = 0; released = 0; ovf_exp = 1'b0; prev_stall = 1'b0;
    clear_capture();
  endtask

  // One clock cycle: drive inputs, tally model disagreements, advance the model.
  task automatic cycle(input bit wv, input logic [23:0] wd, input bit rr, output bit acc);
    bit ewr, rfire, v0;
    int idx;
    wr_valid = wv; wr_data = wd; rd_ready = rr;
    #1;
    ewr = (img_width != 0) && ((written - released) < 2);
    if (wr_ready !== ewr) wr_ready_err++;
    if (bank_full !== exp_bank_full()) bank_err++;
    if (overflow !== ovf_exp) ovf_err++;
    if (prev_stall && (rd_valid !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last))
      hold_err++;
    v0 = (rd_valid === 1'b1);
    rfire = v0 && rr;
    acc = wv && (wr_ready === 1'b1);
    prev_stall = v0 && !rr; prev_data = rd_data; prev_last = rd_last;
    if (wv && !ewr && img_width != 0) ovf_exp = 1'b1;
    if (rfire) begin
      idx = got_data.size();
      if (idx < exp_last.size() && exp_last[idx]) released++;
      got_data.push_back(rd_data); got_last.push_back(rd_last); got_edge.push_back(cyc + 1);
    end
    if (wv && ewr) begin
      partial.push_back(wd);
      if (partial.size() == int'(img_width)) begin
        foreach (partial[i]) begin
          exp_data.push_back(partial[i]);
          exp_last.push_back(i == partial.size() - 1);
        end
        partial.delete(); written++; done_edge = cyc + 1;
      end
    end
    @(posedge clk); #1; cyc++;
    if (!v0 && rd_valid === 1'b1) rise_edge = cyc;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    total++; if (rd_data !== 24'd0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    total++; if (rd_last !== 1'b0) begin bad++; $display("FAIL reset_rd_last: got %b want 0", rd_last); end
    total++; if (bank_full !== 2'b00) begin bad++; $display("FAIL reset_bank_full: got %b want 00", bank_full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    reset = 1'b0; model_reset();
  endtask

  task automatic test_single_line();
    bit acc; int n = 0; int k = 0;
    img_width = 11'd4; clear_capture();
    while (n < 4 && k < 20) begin cycle(1'b1, 24'(n + 1), 1'b1, acc); if (acc) n++; k++; end
    k = 0;
    while (got_data.size() < 4 && k < 30) begin cycle(1'b0, 24'd0, 1'b1, acc); k++; end
    repeat (2) cycle(1'b0, 24'd0, 1'b1, acc);
    total++; if (got_data.size() != 4) begin bad++; $display("FAIL single_count: got %0d want 4", got_data.size()); end
    foreach (got_data[i]) begin
      total++;
      if (got_data[i] !== 24'(i + 1) || got_last[i] !== (i == 3) || got_edge[i] != got_edge[0] + i) begin
        bad++; $display("FAIL single_pix%0d: got data=%h last=%b edge=%0d want data=%h last=%b edge=%0d",
                        i, got_data[i], got_last[i], got_edge[i], 24'(i + 1), (i == 3), got_edge[0] + i);
      end
    end
    total++; if (rise_edge - done_edge != 2) begin bad++; $display("FAIL single_latency: got %0d want 2", rise_edge - done_edge); end
    total++; if (bank_full !== 2'b00) begin bad++; $display("FAIL single_bank_free: got %b want 00", bank_full); end
    total++; if (wr_ready_err + bank_err + ovf_err + hold_err != 0) begin
      bad++; $display("FAIL single_track: got wr_ready=%0d bank=%0d ovf=%0d hold=%0d want all 0",
                      wr_ready_err, bank_err, ovf_err, hold_err);
    end
  endtask

  task automatic test_both_full();
    bit acc; int n = 0; int k = 0;
    img_width = 11'd4; clear_capture();
    for (int c = 1; c <= 12; c++) begin
      cycle(1'b1, 24'(n + 1), 1'b0, acc);
      if (acc) n++;
      if (c == 8) begin
        total++; if (bank_full !== 2'b11) begin bad++; $display("FAIL full_banks: got %b want 11", bank_full); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_wr_ready: got %b want 0", wr_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_ovf_early: got %b want 0", overflow); end
      end
      if (c == 9) begin
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_ovf_set: got %b want 1", overflow); end
      end
    end
    total++; if (n != 8) begin bad++; $display("FAIL full_accepts: got %0d want 8", n); end
    while (got_data.size() < 8 && k < 40) begin cycle(1'b0, 24'd0, 1'b1, acc); k++; end
    total++; if (got_data.size() != 8) begin bad++; $display("FAIL full_count: got %0d want 8", got_data.size()); end
    foreach (got_data[i]) begin
      total++;
      if (got_data[i] !== 24'(i + 1) || got_last[i] !== (i == 3 || i == 7) || got_edge[i] != got_edge[0] + i) begin
        bad++; $display("FAIL full_pix%0d: got data=%h last=%b edge=%0d want data=%h last=%b edge=%0d",
                        i, got_data[i], got_last[i], got_edge[i], 24'(i + 1), (i == 3 || i == 7), got_edge[0] + i);
      end
    end
    total++; if (wr_ready_err + bank_err + ovf_err + hold_err != 0) begin
      bad++; $display("FAIL full_track: got wr_ready=%0d bank=%0d ovf=%0d hold=%0d want all 0",
                      wr_ready_err, bank_err, ovf_err, hold_err);
    end
  endtask

  task automatic test_backpressure();
    bit acc; int n = 0; int k = 0; int lasts = 0;
    logic [23:0] pix[5];
    img_width = 11'd5; clear_capture();
    foreach (pix[i]) pix[i] = 24'($urandom);
    while (n < 5 && k < 20) begin cycle(1'b1, pix[n], 1'b0, acc); if (acc) n++; k++; end
    k = 0;
    while (got_data.size() < 5 && k < 60) begin
      cycle(1'b0, 24'd0, (k % 4 == 0) || (k % 4 == 3), acc); k++;
    end
    total++; if (got_data.size() != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", got_data.size()); end
    foreach (got_data[i]) begin
      if (got_last[i]) lasts++;
      total++;
      if (got_data[i] !== pix[i] || got_last[i] !== (i == 4)) begin
        bad++; $display("FAIL bp_pix%0d: got data=%h last=%b want data=%h last=%b",
                        i, got_data[i], got_last[i], pix[i], (i == 4));
      end
    end
    total++; if (lasts != 1) begin bad++; $display("FAIL bp_last_count: got %0d want 1", lasts); end
    total++; if (hold_err != 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_err); end
  endtask

  task automatic test_width1();
    bit acc; int n = 0; int k = 0;
    logic [23:0] pix[3];
    img_width = 11'd1; clear_capture();
    foreach (pix[i]) pix[i] = 24'($urandom);
    while ((n < 3 || got_data.size() < 3) && k < 40) begin
      cycle(n < 3, (n < 3) ? pix[n] : 24'd0, 1'b1, acc); if (acc) n++; k++;
    end
    total++; if (got_data.size() != 3) begin bad++; $display("FAIL w1_count: got %0d want 3", got_data.size()); end
    foreach (got_data[i]) begin
      total++;
      if (got_data[i] !== pix[i] || got_last[i] !== 1'b1) begin
        bad++; $display("FAIL w1_pix%0d: got data=%h last=%b want data=%h last=1", i, got_data[i], got_last[i], pix[i]);
      end
    end
    total++; if (wr_ready_err + bank_err != 0) begin
      bad++; $display("FAIL w1_track: got wr_ready=%0d bank=%0d want 0", wr_ready_err, bank_err);
    end
  endtask

  task automatic test_reset_mid();
    bit acc; int n = 0; int k = 0;
    logic [23:0] pix[3];
    img_width = 11'd6; clear_capture();
    while (n < 9 && k < 30) begin cycle(1'b1, 24'($urandom) | 24'd1, 1'b0, acc); if (acc) n++; k++; end
    repeat (2) cycle(1'b0, 24'd0, 1'b1, acc);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_stream: got rd_valid=%b want 1", rd_valid); end
    reset = 1'b1; #1;
    total++; if ({rd_valid, rd_last, bank_full, overflow, wr_ready} !== 6'd0) begin
      bad++; $display("FAIL rst_mid_ctrl: got %b want 000000", {rd_valid, rd_last, bank_full, overflow, wr_ready});
    end
    total++; if (rd_data !== 24'd0) begin bad++; $display("FAIL rst_mid_data: got %h want 0", rd_data); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; model_reset();
    img_width = 11'd3;
    foreach (pix[i]) pix[i] = 24'($urandom);
    n = 0; k = 0;
    while ((n < 3 || got_data.size() < 3) && k < 40) begin
      cycle(n < 3, (n < 3) ? pix[n] : 24'd0, 1'b1, acc); if (acc) n++; k++;
    end
    repeat (10) cycle(1'b0, 24'd0, 1'b1, acc);
    total++; if (got_data.size() != 3) begin bad++; $display("FAIL rst_fresh_count: got %0d want 3", got_data.size()); end
    foreach (got_data[i]) begin
      total++;
      if (got_data[i] !== pix[i] || got_last[i] !== (i == 2)) begin
        bad++; $display("FAIL rst_fresh_pix%0d: got data=%h last=%b want data=%h last=%b",
                        i, got_data[i], got_last[i], pix[i], (i == 2));
      end
    end
  endtask

  task automatic test_zero_width();
    bit acc; int ready_seen = 0; int valid_seen = 0;
    img_width = 11'd0; clear_capture();
    repeat (12) begin
      cycle(1'b1, 24'($urandom), 1'b1, acc);
      if (wr_ready !== 1'b0) ready_seen++;
      if (rd_valid !== 1'b0) valid_seen++;
    end
    total++; if (ready_seen != 0) begin bad++; $display("FAIL zw_wr_ready: got %0d high cycles want 0", ready_seen); end
    total++; if (valid_seen != 0) begin bad++; $display("FAIL zw_rd_valid: got %0d high cycles want 0", valid_seen); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL zw_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_random();
    bit acc; int n, k, w, px;
    logic [23:0] cur;
    for (int r = 0; r < 3; r++) begin
      w = $urandom_range(1, 7); img_width = 11'(w); clear_capture();
      px = w * 4; n = 0; k = 0; cur = 24'($urandom);
      while (n < px && k < 3000) begin
        cycle(($urandom % 10) < 7, cur, ($urandom % 10) < 6, acc);
        if (acc) begin n++; cur = 24'($urandom); end
        k++;
      end
      k = 0;
      while (got_data.size() < exp_data.size() && k < 200) begin cycle(1'b0, 24'd0, 1'b1, acc); k++; end
      total++; if (got_data.size() != px) begin bad++; $display("FAIL rnd%0d_count: got %0d want %0d", r, got_data.size(), px); end
      foreach (got_data[i]) begin
        if (i < exp_data.size()) begin
          total++;
          if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
            bad++; $display("FAIL rnd%0d_pix%0d: got data=%h last=%b want data=%h last=%b",
                            r, i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
          end
        end
      end
      total++; if (wr_ready_err + bank_err + ovf_err + hold_err != 0) begin
        bad++; $display("FAIL rnd%0d_track: got wr_ready=%0d bank=%0d ovf=%0d hold=%0d want all 0",
                        r, wr_ready_err, bank_err, ovf_err, hold_err);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_line();
    test_both_full();
    test_backpressure();
    test_width1();
    test_reset_mid();
    test_zero_width();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
